// File: rtl/cpu_pkg.sv
// Shared CPU types: condition-code encoding, sequencer FSM states and PC width.
package cpu_pkg;

  localparam int PC_WIDTH = 8;

  typedef enum logic [2:0] {
    NEVER        = 3'b000,
    EQUAL        = 3'b001,
    LESS         = 3'b010,
    LESSEQUAL    = 3'b011,
    ALWAYS       = 3'b100,
    NOTEQUAL     = 3'b101,
    GREATER      = 3'b110,
    GREATEREQUAL = 3'b111
  } cond_op_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_EVAL   = 2'b01,
    ST_COMMIT = 2'b10,
    ST_HALTED = 2'b11
  } seq_state_t;

endpackage

// File: rtl/branch_sequencer_cond.sv
// ConditionalUnit: tests a two's-complement operand against zero per condition code.
module ConditionalUnit
  import cpu_pkg::*;
(
  input  logic [2:0] opcode,
  input  logic [7:0] operand,
  output logic       result
);

  logic w_zero;
  logic w_neg;

  assign w_zero = (operand == 8'h00);
  assign w_neg  = operand[7];

  // Decode condition code into a pass/fail against the operand sign and zero flags.
  always_comb begin
    result = 1'b0;
    case (cond_op_t'(opcode))
      NEVER:        result = 1'b0;
      EQUAL:        result = w_zero;
      LESS:         result = w_neg;
      LESSEQUAL:    result = w_neg | w_zero;
      ALWAYS:       result = 1'b1;
      NOTEQUAL:     result = ~w_zero;
      GREATER:      result = ~(w_neg | w_zero);
      GREATEREQUAL: result = ~w_neg;
      default:      result = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_sequencer.sv
// Program-counter sequencer: accepts one control-flow step, evaluates its
// condition, then commits PC+1 or the jump target (pulsing taken/flush).
module branch_sequencer
  import cpu_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0] RESET_PC = 8'h00
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                step_valid,
  output logic                step_ready,
  input  logic                is_jump,
  input  logic [2:0]          cond_opcode,
  input  logic [7:0]          cond_operand,
  input  logic [PC_WIDTH-1:0] jump_target,
  input  logic                halt,
  output logic [PC_WIDTH-1:0] pc,
  output logic                taken,
  output logic                flush,
  output logic                halted
);

  seq_state_t          r_state;
  seq_state_t          w_next;
  logic [PC_WIDTH-1:0] r_pc;
  logic                r_is_jump;
  logic [2:0]          r_opcode;
  logic [7:0]          r_operand;
  logic [PC_WIDTH-1:0] r_target;
  logic                r_cond_hit;
  logic                w_cond_result;

  // The evaluator only sees latched step fields, so decoder changes after acceptance are ignored.
  ConditionalUnit u_cond (
    .opcode  (r_opcode),
    .operand (r_operand),
    .result  (w_cond_result)
  );

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode and state-derived handshake/status outputs.
  always_comb begin
    w_next     = r_state;
    step_ready = 1'b0;
    halted     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        step_ready = 1'b1;
        if (step_valid) begin
          w_next = ST_EVAL;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_EVAL: begin
        w_next = ST_COMMIT;
      end
      ST_COMMIT: begin
        if (halt) begin
          w_next = ST_HALTED;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_HALTED: begin
        halted = 1'b1;
        if (!halt) begin
          w_next = ST_IDLE;
        end else begin
          w_next = ST_HALTED;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Step capture, condition registration and PC commit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pc       <= RESET_PC;
      r_is_jump  <= 1'b0;
      r_opcode   <= 3'b000;
      r_operand  <= 8'h00;
      r_target   <= {PC_WIDTH{1'b0}};
      r_cond_hit <= 1'b0;
    end else begin
      if ((r_state == ST_IDLE) && step_valid) begin
        r_is_jump <= is_jump;
        r_opcode  <= cond_opcode;
        r_operand <= cond_operand;
        r_target  <= jump_target;
      end
      if (r_state == ST_EVAL) begin
        r_cond_hit <= r_is_jump & w_cond_result;
      end
      // PC wraps naturally at the top of the address space.
      if (r_state == ST_COMMIT) begin
        r_pc <= r_cond_hit ? r_target : (r_pc + {{(PC_WIDTH-1){1'b0}}, 1'b1});
      end
    end
  end

  assign pc    = r_pc;
  assign taken = (r_state == ST_COMMIT) && r_cond_hit;
  assign flush = (r_state == ST_COMMIT) && r_cond_hit;

endmodule

// File: tb/tb_branch_sequencer.sv
// Self-checking bench for branch_sequencer: directed scenarios plus randomized
// steps against a behavioural PC model.
module tb_branch_sequencer;

  logic       clock;
  logic       reset_n;
  logic       step_valid;
  logic       step_ready;
  logic       is_jump;
  logic [2:0] cond_opcode;
  logic [7:0] cond_operand;
  logic [7:0] jump_target;
  logic       halt;
  logic [7:0] pc;
  logic       taken;
  logic       flush;
  logic       halted;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_accept = 0;
  logic [7:0] m_pc;

  branch_sequencer #(.RESET_PC(8'h10)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .step_valid   (step_valid),
    .step_ready   (step_ready),
    .is_jump      (is_jump),
    .cond_opcode  (cond_opcode),
    .cond_operand (cond_operand),
    .jump_target  (jump_target),
    .halt         (halt),
    .pc           (pc),
    .taken        (taken),
    .flush        (flush),
    .halted       (halted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic bit ref_taken(input bit jmp, input logic [2:0] op, input logic [7:0] val);
    int v;
    bit r;
    v = int'($signed(val));
    case (op)
      3'd0: r = 1'b0;
      3'd1: r = (v == 0);
      3'd2: r = (v < 0);
      3'd3: r = (v <= 0);
      3'd4: r = 1'b1;
      3'd5: r = (v != 0);
      3'd6: r = (v > 0);
      default: r = (v >= 0);
    endcase
    return jmp && r;
  endfunction

  task automatic wait_ready();
    int n = 0;
    @(negedge clock);
    while (step_ready !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (step_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_timeout: step_ready=%b required 1", step_ready);
    end
  endtask

  // One full step: accept, check EVAL/COMMIT behaviour, check committed PC.
  task automatic do_step(input bit jmp, input logic [2:0] op, input logic [7:0] opnd,
                         input logic [7:0] tgt, input bit halt_in);
    bit exp_t;
    exp_t = ref_taken(jmp, op, opnd);
    wait_ready();
    step_valid   = 1'b1;
    is_jump      = jmp;
    cond_opcode  = op;
    cond_operand = opnd;
    jump_target  = tgt;
    @(posedge clock);
    #1;
    last_accept  = cyc;
    step_valid   = 1'b0;
    is_jump      = 1'($urandom);
    cond_opcode  = 3'($urandom);
    cond_operand = 8'($urandom);
    jump_target  = 8'($urandom);
    checks++;
    if (step_ready !== 1'b0 || taken !== 1'b0) begin
      errors++;
      $display("FAIL eval_state: ready=%b taken=%b required 0/0", step_ready, taken);
    end
    @(posedge clock);
    #1;
    checks++;
    if (taken !== exp_t || flush !== exp_t) begin
      errors++;
      $display("FAIL commit_pulse op=%0d opnd=%h: taken=%b flush=%b required %b", op, opnd, taken, flush, exp_t);
    end
    halt = halt_in;
    @(posedge clock);
    #1;
    m_pc = exp_t ? tgt : m_pc + 8'd1;
    checks++;
    if (pc !== m_pc || taken !== 1'b0 || halted !== halt_in || step_ready !== !halt_in) begin
      errors++;
      $display("FAIL commit_pc op=%0d opnd=%h: pc=%h taken=%b halted=%b ready=%b required pc=%h 0 %b %b",
               op, opnd, pc, taken, halted, step_ready, m_pc, halt_in, !halt_in);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    m_pc = 8'h10;
    checks++;
    if (pc !== 8'h10 || step_ready !== 1'b1 || taken !== 1'b0 || flush !== 1'b0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL reset: pc=%h ready=%b taken=%b flush=%b halted=%b required 10 1 0 0 0",
               pc, step_ready, taken, flush, halted);
    end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_sequential();
    int prev;
    do_step(1'b0, 3'd4, 8'h00, 8'h55, 1'b0);
    prev = last_accept;
    for (int i = 0; i < 2; i++) begin
      do_step(1'b0, 3'd4, 8'h00, 8'h55, 1'b0);
      checks++;
      if (last_accept - prev != 3) begin
        errors++;
        $display("FAIL seq_spacing: %0d cycles required 3", last_accept - prev);
      end
      prev = last_accept;
    end
    checks++;
    if (pc !== 8'h13) begin
      errors++;
      $display("FAIL seq_pc: pc=%h required 13", pc);
    end
  endtask

  task automatic test_cond_sweep();
    logic [7:0] ops [3];
    ops[0] = 8'h00;
    ops[1] = 8'hFF;
    ops[2] = 8'h0F;
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 8; c++) begin
        do_step(1'b1, 3'(c), ops[k], 8'hA0, 1'b0);
      end
    end
    do_step(1'b1, 3'd2, 8'h80, 8'h33, 1'b0);
    do_step(1'b1, 3'd6, 8'h7F, 8'h44, 1'b0);
  endtask

  task automatic test_wrap();
    do_step(1'b1, 3'd4, 8'h00, 8'hFF, 1'b0);
    do_step(1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
    checks++;
    if (pc !== 8'h00) begin
      errors++;
      $display("FAIL wrap: pc=%h required 00", pc);
    end
    do_step(1'b1, 3'd1, 8'h00, 8'hFF, 1'b0);
    do_step(1'b1, 3'd4, 8'h00, 8'hFF, 1'b0);
  endtask

  task automatic test_halt();
    do_step(1'b0, 3'd0, 8'h00, 8'h00, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      checks++;
      if (pc !== m_pc || halted !== 1'b1 || step_ready !== 1'b0) begin
        errors++;
        $display("FAIL halt_hold: pc=%h halted=%b ready=%b required %h 1 0", pc, halted, step_ready, m_pc);
      end
    end
    halt = 1'b0;
    @(negedge clock);
    checks++;
    if (halted !== 1'b0 || step_ready !== 1'b1) begin
      errors++;
      $display("FAIL halt_exit: halted=%b ready=%b required 0 1", halted, step_ready);
    end
    halt = 1'b1;
    do_step(1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
  endtask

  task automatic test_reset_midop();
    bit seen_taken = 1'b0;
    wait_ready();
    step_valid   = 1'b1;
    is_jump      = 1'b1;
    cond_opcode  = 3'd4;
    cond_operand = 8'h00;
    jump_target  = 8'hC3;
    @(posedge clock);
    #1;
    step_valid = 1'b0;
    reset_n    = 1'b0;
    m_pc       = 8'h10;
    #1;
    checks++;
    if (pc !== 8'h10 || step_ready !== 1'b1 || taken !== 1'b0) begin
      errors++;
      $display("FAIL midop_reset: pc=%h ready=%b taken=%b required 10 1 0", pc, step_ready, taken);
    end
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (taken !== 1'b0 || pc !== 8'h10) seen_taken = 1'b1;
    end
    checks++;
    if (seen_taken) begin
      errors++;
      $display("FAIL midop_abandon: taken or pc change after reset, pc=%h required 10", pc);
    end
    do_step(1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      do_step(1'($urandom), 3'($urandom), 8'($urandom), 8'($urandom), 1'b0);
    end
  endtask

  initial begin
    step_valid   = 1'b0;
    is_jump      = 1'b0;
    cond_opcode  = 3'd0;
    cond_operand = 8'h00;
    jump_target  = 8'h00;
    halt         = 1'b1;
    m_pc         = 8'h10;
    test_reset();
    test_sequential();
    test_cond_sweep();
    test_wrap();
    test_halt();
    test_reset_midop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
